// File: rtl/msk_pkg.sv
// rtl/msk_pkg.sv - shared types and constants for the MSK frame synchronizer
//
// Purpose: state encoding, default sync word and byte width used by
// msk_frame_sync and its testbench.
// Ports: none (package).

package msk_pkg;

  typedef enum logic [0:0] {
    SEARCH  = 1'b0,
    PAYLOAD = 1'b1
  } fsync_state_t;

  // CCSDS attached sync marker, sent MSB first.
  localparam logic [31:0] MSK_DEFAULT_SYNC = 32'h1ACF_FC1D;

  localparam int MSK_BYTE_W = 8;

endpackage

// File: rtl/msk_frame_sync_if.sv
// rtl/msk_frame_sync_if.sv - signal bundle between slicer, frame sync and packet layer
//
// Purpose: groups the bit-stream input and the deframed byte-stream output.
// Modports:
//   master : bit source / byte sink side (drives data_i, data_valid_i)
//   slave  : frame synchronizer side (drives byte and status outputs)

interface msk_frame_sync_if;
  import msk_pkg::*;

  logic                  data_i;
  logic                  data_valid_i;
  logic [MSK_BYTE_W-1:0] byte_o;
  logic                  byte_valid_o;
  logic                  sof_o;
  logic                  eof_o;
  logic                  sync_det_o;
  logic                  locked_o;
  logic                  inverted_o;
  logic [15:0]           frame_cnt_o;

  modport master (
    output data_i, data_valid_i,
    input  byte_o, byte_valid_o, sof_o, eof_o, sync_det_o, locked_o,
           inverted_o, frame_cnt_o
  );

  modport slave (
    input  data_i, data_valid_i,
    output byte_o, byte_valid_o, sof_o, eof_o, sync_det_o, locked_o,
           inverted_o, frame_cnt_o
  );

endinterface

// File: rtl/msk_popcount.sv
// rtl/msk_popcount.sv - combinational Hamming weight of a W-bit vector
//
// Purpose: counts set bits; used to measure sync-word bit mismatches.
// Ports:
//   vec   in  W               vector to weigh
//   count out $clog2(W+1)     number of ones in vec

module msk_popcount #(
  parameter int W = 32
) (
  input  logic [W-1:0]           vec,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/msk_frame_sync.sv
// rtl/msk_frame_sync.sv - MSK bit-stream frame synchronizer and byte deframer
//
// Purpose: searches the hard-bit stream for SYNC_WORD (up to MAX_ERR bit
// mismatches), then packs the next PAYLOAD_BYTES bytes MSB first with
// start/end-of-frame markers.
// Optional feature: define MSK_FSYNC_INV_EN to also accept the inverted sync
// word; payload of such a frame is re-inverted and inverted_o is set.
// Ports:
//   clk, reset_n (async, active low)
//   data_i, data_valid_i          hard bit in + strobe
//   byte_o, byte_valid_o          payload byte out + strobe
//   sof_o, eof_o                  first / last payload byte markers
//   sync_det_o                    pulse on sync acceptance
//   locked_o                      high while receiving payload
//   inverted_o                    current frame used the inverted sync word
//   frame_cnt_o                   completed frames (wraps)

module msk_frame_sync
  import msk_pkg::*;
#(
  parameter int                SYNC_W        = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD     = SYNC_W'(MSK_DEFAULT_SYNC),
  parameter int                MAX_ERR       = 2,
  parameter int                PAYLOAD_BYTES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  data_i,
  input  logic                  data_valid_i,
  output logic [MSK_BYTE_W-1:0] byte_o,
  output logic                  byte_valid_o,
  output logic                  sof_o,
  output logic                  eof_o,
  output logic                  sync_det_o,
  output logic                  locked_o,
  output logic                  inverted_o,
  output logic [15:0]           frame_cnt_o
);

  localparam int PC_W = $clog2(SYNC_W + 1);
  localparam int BC_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(PAYLOAD_BYTES - 1);

  fsync_state_t          state;
  // Only the previous SYNC_W-1 bits need storing: the candidate window is
  // completed by the incoming bit.
  logic [SYNC_W-2:0]     hist;
  logic [SYNC_W-1:0]     cand;
  logic [PC_W-1:0]       fill;
  logic [PC_W-1:0]       err_true;
  logic                  window_full;
  logic                  hit_true;
  logic                  sync_hit;
  logic                  pay_bit;
  logic [MSK_BYTE_W-2:0] asm_q;
  logic [2:0]            bit_cnt;
  logic [BC_W-1:0]       byte_cnt;

  assign cand = {hist, data_i};

  msk_popcount #(.W(SYNC_W)) u_pc_true (
    .vec   (cand ^ SYNC_WORD),
    .count (err_true)
  );

  // Window holds SYNC_W fresh bits once the incoming bit is the SYNC_W-th
  // since entering SEARCH (or the fill count has already saturated).
  assign window_full = (fill == PC_W'(SYNC_W - 1)) || (fill == PC_W'(SYNC_W));
  assign hit_true    = window_full && (int'(err_true) <= MAX_ERR);

`ifdef MSK_FSYNC_INV_EN
  logic [PC_W-1:0] err_inv;
  logic            hit_inv;

  msk_popcount #(.W(SYNC_W)) u_pc_inv (
    .vec   (cand ^ ~SYNC_WORD),
    .count (err_inv)
  );

  assign hit_inv  = window_full && (int'(err_inv) <= MAX_ERR);
  assign sync_hit = hit_true || hit_inv;
  assign pay_bit  = data_i ^ inverted_o;

  // A true hit takes precedence when both polarities match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inverted_o <= 1'b0;
    end else if (data_valid_i && (state == SEARCH) && sync_hit) begin
      inverted_o <= !hit_true;
    end
  end
`else
  assign sync_hit   = hit_true;
  assign pay_bit    = data_i;
  assign inverted_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SEARCH;
      hist         <= '0;
      fill         <= '0;
      asm_q        <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      byte_o       <= '0;
      byte_valid_o <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      sync_det_o   <= 1'b0;
      locked_o     <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      byte_valid_o <= 1'b0;
      sof_o        <= 1'b0;
      eof_o        <= 1'b0;
      sync_det_o   <= 1'b0;
      if (data_valid_i) begin
        hist <= cand[SYNC_W-2:0];
        case (state)
          SEARCH: begin
            if (fill != PC_W'(SYNC_W)) fill <= fill + PC_W'(1);
            if (sync_hit) begin
              state      <= PAYLOAD;
              sync_det_o <= 1'b1;
              locked_o   <= 1'b1;
              bit_cnt    <= '0;
              byte_cnt   <= '0;
            end
          end
          PAYLOAD: begin
            asm_q   <= {asm_q[MSK_BYTE_W-3:0], pay_bit};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_o       <= {asm_q, pay_bit};
              byte_valid_o <= 1'b1;
              sof_o        <= (byte_cnt == '0);
              if (byte_cnt == LAST_BYTE) begin
                // Back to SEARCH with an empty window so the next sync word
                // must arrive complete.
                eof_o       <= 1'b1;
                locked_o    <= 1'b0;
                state       <= SEARCH;
                fill        <= '0;
                byte_cnt    <= '0;
                frame_cnt_o <= frame_cnt_o + 16'd1;
              end else begin
                byte_cnt <= byte_cnt + BC_W'(1);
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msk_frame_sync.sv
// tb/tb_msk_frame_sync.sv - self-checking bench for msk_frame_sync

module tb_msk_frame_sync;
  import msk_pkg::*;

  typedef struct {
    logic [7:0] b;
    logic       sof;
    logic       eof;
    logic       inv;
  } exp_t;

  localparam logic [31:0] SW = 32'h1ACF_FC1D;
  localparam int NB = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  msk_frame_sync_if ifc ();

  msk_frame_sync dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .data_i       (ifc.data_i),
    .data_valid_i (ifc.data_valid_i),
    .byte_o       (ifc.byte_o),
    .byte_valid_o (ifc.byte_valid_o),
    .sof_o        (ifc.sof_o),
    .eof_o        (ifc.eof_o),
    .sync_det_o   (ifc.sync_det_o),
    .locked_o     (ifc.locked_o),
    .inverted_o   (ifc.inverted_o),
    .frame_cnt_o  (ifc.frame_cnt_o)
  );

  exp_t       sb[$];
  logic [7:0] pay[NB];
  int checks = 0;
  int errors = 0;
  int sync_cnt = 0;
  int byte_cnt = 0;
  logic last_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input strobe as seen by the DUT at the most recent rising edge.
  always @(posedge clk) last_valid <= ifc.data_valid_i;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ifc.sync_det_o) begin
        sync_cnt++;
        check("sync_follows_valid", 32'(last_valid), 32'd1);
      end
      if (ifc.byte_valid_o) begin
        byte_cnt++;
        check("byte_follows_valid", 32'(last_valid), 32'd1);
        check("byte_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("byte_val", 32'(ifc.byte_o), 32'(e.b));
          check("sof", 32'(ifc.sof_o), 32'(e.sof));
          check("eof", 32'(ifc.eof_o), 32'(e.eof));
          check("inverted", 32'(ifc.inverted_o), 32'(e.inv));
        end
      end else if (ifc.sof_o || ifc.eof_o) begin
        check("marker_without_byte", {30'd0, ifc.sof_o, ifc.eof_o}, 32'd0);
      end
    end
  end

  task automatic send_bit(input logic b, input int gap);
    @(negedge clk);
    ifc.data_i = b;
    ifc.data_valid_i = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      ifc.data_valid_i = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ifc.data_valid_i = 1'b0;
    repeat (n) @(negedge clk);
    #2;
  endtask

  // Sends sync word sw and nbytes of pay[] (xor flip on the wire); pushes
  // the expected decoded bytes.
  task automatic send_frame(input logic [31:0] sw, input int nbytes, input int gap,
                            input logic flip, input logic exp_inv);
    send_bits(sw, 32, gap);
    for (int k = 0; k < nbytes; k++) begin
      exp_t e;
      e.b = pay[k];
      e.sof = (k == 0);
      e.eof = (k == NB - 1);
      e.inv = exp_inv;
      sb.push_back(e);
      send_bits(32'(pay[k] ^ {8{flip}}), 8, gap);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    #2;
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte"}, 32'(ifc.byte_o), 32'd0);
    check({tag, "_frame_cnt"}, 32'(ifc.frame_cnt_o), 32'd0);
    check({tag, "_flags"}, {26'd0, ifc.byte_valid_o, ifc.sof_o, ifc.eof_o,
                            ifc.sync_det_o, ifc.locked_o, ifc.inverted_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, b0;
    ifc.data_i = 1'b0;
    ifc.data_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Random preamble, sync, payload 0x00..0x3F, strobe every 4th cycle.
    for (int i = 0; i < 100; i++) send_bit(1'($urandom_range(0, 1)), 3);
    for (int k = 0; k < NB; k++) pay[k] = 8'(k);
    send_frame(SW, 1, 3, 1'b0, 1'b0);
    #2;
    check("locked_in_payload", 32'(ifc.locked_o), 32'd1);
    for (int k = 1; k < NB; k++) begin
      exp_t e;
      e.b = pay[k]; e.sof = 1'b0; e.eof = (k == NB - 1); e.inv = 1'b0;
      sb.push_back(e);
      send_bits(32'(pay[k]), 8, 3);
    end
    idle(3);
    wait_drain("t1");
    check("t1_sync_cnt", 32'(sync_cnt), 32'd1);
    check("t1_frame_cnt", 32'(ifc.frame_cnt_o), 32'd1);
    check("t1_unlocked", 32'(ifc.locked_o), 32'd0);

    // Two bit errors in the sync word: accepted.
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
    send_frame(SW ^ 32'h0010_0008, NB, 0, 1'b0, 1'b0);
    idle(3);
    wait_drain("t2");
    check("t2_sync_cnt", 32'(sync_cnt), 32'd2);
    check("t2_frame_cnt", 32'(ifc.frame_cnt_o), 32'd2);

    // Three bit errors: rejected.
    s0 = sync_cnt;
    b0 = byte_cnt;
    send_bits(SW ^ 32'h0100_1002, 32, 0);
    send_bits(32'h0, 16, 0);
    idle(3);
    check("t3_no_sync", 32'(sync_cnt), 32'(s0));
    check("t3_not_locked", 32'(ifc.locked_o), 32'd0);
    check("t3_no_bytes", 32'(byte_cnt), 32'(b0));

    // Back-to-back frames, strobe every cycle.
    b0 = byte_cnt;
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
    send_frame(SW, NB, 0, 1'b0, 1'b0);
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
    send_frame(SW, NB, 0, 1'b0, 1'b0);
    idle(3);
    wait_drain("t4");
    check("t4_bytes", 32'(byte_cnt - b0), 32'd128);
    check("t4_frame_cnt", 32'(ifc.frame_cnt_o), 32'd4);
    check("t4_sync_cnt", 32'(sync_cnt), 32'd4);

    // Sync pattern embedded in the payload.
    for (int k = 0; k < NB; k++) pay[k] = 8'(k * 3 + 1);
    pay[10] = 8'h1A; pay[11] = 8'hCF; pay[12] = 8'hFC; pay[13] = 8'h1D;
    send_frame(SW, NB, 1, 1'b0, 1'b0);
    idle(3);
    wait_drain("t5");
    check("t5_sync_cnt", 32'(sync_cnt), 32'd5);
    check("t5_frame_cnt", 32'(ifc.frame_cnt_o), 32'd5);

    // Reset after 10 payload bytes, then a complete frame.
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
    send_frame(SW, 10, 0, 1'b0, 1'b0);
    idle(2);
    wait_drain("t6a");
    check("t6_locked_before_reset", 32'(ifc.locked_o), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    check_reset_outputs("t6_in_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < NB; k++) pay[k] = 8'($urandom);
    send_frame(SW, NB, 0, 1'b0, 1'b0);
    idle(3);
    wait_drain("t6b");
    check("t6_frame_cnt", 32'(ifc.frame_cnt_o), 32'd1);

    // Inverted sync word with inverted 0xA5 payload.
    s0 = sync_cnt;
    b0 = byte_cnt;
    for (int k = 0; k < NB; k++) pay[k] = 8'hA5;
`ifdef MSK_FSYNC_INV_EN
    send_frame(~SW, NB, 0, 1'b1, 1'b1);
    idle(3);
    wait_drain("t7");
    check("t7_sync_cnt", 32'(sync_cnt), 32'(s0 + 1));
    check("t7_frame_cnt", 32'(ifc.frame_cnt_o), 32'd2);
`else
    send_bits(~SW, 32, 0);
    for (int k = 0; k < NB; k++) send_bits(32'(~pay[k]), 8, 0);
    idle(3);
    check("t7_no_sync", 32'(sync_cnt), 32'(s0));
    check("t7_not_locked", 32'(ifc.locked_o), 32'd0);
    check("t7_no_bytes", 32'(byte_cnt), 32'(b0));
    check("t7_frame_cnt", 32'(ifc.frame_cnt_o), 32'd1);
`endif

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
